// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
// Optional match counter is enabled by defining SEQ_DET_MATCH_COUNT_EN.
package seq_det_pkg;

  localparam logic [3:0]  DEF_PATTERN = 4'b1010;
  localparam int unsigned DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2
  } state_e;

  // Out-of-range lengths (0 or above the maximum) select the full window.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register, fill counter and window comparator of the detector.
// Match condition is evaluated on the post-shift history and fill values.
module seq_det_window #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_overlap,
  output logic               o_match_c,
  output logic               o_full_c,
  output logic               o_full_next_c
);

  logic [MAX_LEN-1:0] r_history;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_history_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;

  always_comb begin
    w_history_next = {r_history[MAX_LEN-2:0], i_bit};
    w_fill_next    = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    w_mask         = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  assign o_match_c     = i_shift && (w_fill_next >= i_len) &&
                         ((w_history_next & w_mask) == (i_pattern & w_mask));
  assign o_full_c      = (r_fill >= i_len);
  assign o_full_next_c = (w_fill_next >= i_len);

  // Non-overlap mode restarts the fill count so the next match needs fresh bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (i_clear) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (i_shift) begin
      r_history <= w_history_next;
      r_fill    <= (o_match_c && !i_overlap) ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// Runtime-programmable Moore serial pattern detector with registered match pulse.
// Define SEQ_DET_MATCH_COUNT_EN to build the saturating match counter.
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  state_e             r_state;
  state_e             w_state_next;
  logic               r_out;
  logic               w_accept;
  logic               w_match;
  logic               w_full;
  logic               w_full_next;

  assign w_accept = in_valid && !cfg_load;

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (cfg_load),
    .i_shift       (w_accept),
    .i_bit         (in),
    .i_pattern     (r_pattern),
    .i_len         (r_len),
    .i_overlap     (r_overlap),
    .o_match_c     (w_match),
    .o_full_c      (w_full),
    .o_full_next_c (w_full_next)
  );

  // Configuration registers; reset restores the fixed 1010 detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= MAX_LEN'(DEF_PATTERN);
      r_len     <= LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
      r_overlap <= DEF_OVERLAP;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      r_overlap <= cfg_overlap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= (w_state_next == MATCH);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (cfg_load) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE, ARMED: begin
          if (in_valid) begin
            w_state_next = w_match ? MATCH : (w_full_next ? ARMED : IDLE);
          end
        end
        MATCH: begin
          if (in_valid) begin
            w_state_next = w_match ? MATCH : (w_full_next ? ARMED : IDLE);
          end else begin
            w_state_next = w_full ? ARMED : IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign out = r_out;

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Counts cycles in which out is being set, holding at the maximum value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (cfg_load) begin
      r_count <= '0;
    end else if ((w_state_next == MATCH) && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule
